mips_wb_queue: RTL and testbench

Write-back queue between the execute/memory stages and the MIPS register file's single write port. Producers push (destination register, result) pairs. The block buffers them in order and drains at most one per cycle onto the register file's write port (addrW/BusW/wEn). Reads of the register file see pending results through either a forwarding path or a stall, selected at compile time.

---
 rtl/mips_wb_queue.sv | 118 +++++++++++
 tb/tb_mips_wb_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_wb_queue.sv
// In-order write-back queue feeding the register file's single write port.
// Define WBQ_FWD_EN to forward pending results; otherwise hazards raise raw_stall.
module mips_wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_addr,
    input  logic [DW-1:0]          in_data,
    input  logic                   wb_hold,
    output logic [AW-1:0]          addrW,
    output logic [DW-1:0]          BusW,
    output logic                   wEn,
    input  logic [AW-1:0]          addrA,
    input  logic [AW-1:0]          addrB,
    output logic                   fwdA_hit,
    output logic                   fwdB_hit,
    output logic [DW-1:0]          fwdA_data,
    output logic [DW-1:0]          fwdB_data,
    output logic                   raw_stall,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          full;
    logic          empty;
    logic          push;
    logic          store;
    logic          match_a;
    logic          match_b;
    logic [PW-1:0] idx;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // Writes to $0 complete the handshake but are dropped.
    assign store    = push && (in_addr != '0);
    assign wEn      = !empty && !wb_hold;
    assign addrW    = addr_mem[head];
    assign BusW     = data_mem[head];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store) tail <= tail + 1'b1;
            if (wEn)   head <= head + 1'b1;
            count <= count + CW'(store) - CW'(wEn);
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (rst_n && store) begin
            addr_mem[tail] <= in_addr;
            data_mem[tail] <= in_data;
        end
    end

`ifdef WBQ_FWD_EN
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
`endif

    // Walk oldest to youngest so the youngest match is the last one written.
    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        idx     = '0;
`ifdef WBQ_FWD_EN
        data_a  = '0;
        data_b  = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PW'(k);
            if (CW'(k) < count) begin
                if (addrA != '0 && addr_mem[idx] == addrA) begin
                    match_a = 1'b1;
`ifdef WBQ_FWD_EN
                    data_a  = data_mem[idx];
`endif
                end
                if (addrB != '0 && addr_mem[idx] == addrB) begin
                    match_b = 1'b1;
`ifdef WBQ_FWD_EN
                    data_b  = data_mem[idx];
`endif
                end
            end
        end
    end

`ifdef WBQ_FWD_EN
    assign fwdA_hit  = match_a;
    assign fwdB_hit  = match_b;
    assign fwdA_data = data_a;
    assign fwdB_data = data_b;
    assign raw_stall = 1'b0;
`else
    assign fwdA_hit  = 1'b0;
    assign fwdB_hit  = 1'b0;
    assign fwdA_data = '0;
    assign fwdB_data = '0;
    assign raw_stall = match_a || match_b;
`endif
endmodule

// File: tb/tb_mips_wb_queue.sv
// Self-checking bench for mips_wb_queue: directed scenarios plus randomized traffic
// against a queue-based reference model; honours WBQ_FWD_EN like the design.
module tb_mips_wb_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wb_hold;
    logic [4:0]  addrW;
    logic [31:0] BusW;
    logic        wEn;
    logic [4:0]  addrA;
    logic [4:0]  addrB;
    logic        fwdA_hit;
    logic        fwdB_hit;
    logic [31:0] fwdA_data;
    logic [31:0] fwdB_data;
    logic        raw_stall;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    ent_t        mq[$];
    logic        exp_ready;
    logic        exp_wen;
    logic [2:0]  exp_count;
    logic        exp_hit_a;
    logic        exp_hit_b;
    logic [31:0] exp_data_a;
    logic [31:0] exp_data_b;
    logic        exp_stall;

    mips_wb_queue #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .wb_hold(wb_hold),
        .addrW(addrW), .BusW(BusW), .wEn(wEn), .addrA(addrA), .addrB(addrB),
        .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit), .fwdA_data(fwdA_data),
        .fwdB_data(fwdB_data), .raw_stall(raw_stall), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: expected combinational outputs from the pending list.
    task automatic model_eval();
        logic ma, mb;
        logic [31:0] da, db;
        ma = 1'b0; mb = 1'b0; da = '0; db = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!ma && addrA != 0 && mq[i].a == addrA) begin ma = 1'b1; da = mq[i].d; end
            if (!mb && addrB != 0 && mq[i].a == addrB) begin mb = 1'b1; db = mq[i].d; end
        end
        exp_ready = (mq.size() < DEPTH);
        exp_wen   = (mq.size() != 0) && !wb_hold;
        exp_count = 3'(mq.size());
`ifdef WBQ_FWD_EN
        exp_hit_a = ma; exp_hit_b = mb; exp_data_a = da; exp_data_b = db; exp_stall = 1'b0;
`else
        exp_hit_a = 1'b0; exp_hit_b = 1'b0; exp_data_a = '0; exp_data_b = '0; exp_stall = ma | mb;
`endif
    endtask

    // One clock edge with current inputs; the model follows the same edge.
    task automatic tick();
        logic do_push, do_pop;
        model_eval();
        do_push = in_valid && exp_ready && (in_addr != 0);
        do_pop  = exp_wen;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{a: in_addr, d: in_data});
        end
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        wb_hold = 1'b0; addrA = '0; addrB = '0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready: got %b want 1", in_ready); end
        n_cmp++; if (wEn !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wen: got %b want 0", wEn); end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (fwdA_hit !== 1'b0 || fwdB_hit !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_hit: got %b%b want 00", fwdA_hit, fwdB_hit); end
        n_cmp++; if (fwdA_data !== 32'h0 || fwdB_data !== 32'h0) begin n_bad++; $display("[TB] FAIL reset_fwd_data: got %h %h want 0", fwdA_data, fwdB_data); end
        n_cmp++; if (raw_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_stall: got %b want 0", raw_stall); end
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_addr = 5'd3; in_data = 32'h11;
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (wEn !== 1'b1) begin n_bad++; $display("[TB] FAIL single_wen: got %b want 1", wEn); end
        n_cmp++; if (addrW !== 5'd3) begin n_bad++; $display("[TB] FAIL single_addrW: got %0d want 3", addrW); end
        n_cmp++; if (BusW !== 32'h11) begin n_bad++; $display("[TB] FAIL single_BusW: got %h want 11", BusW); end
        n_cmp++; if (count !== 3'd1) begin n_bad++; $display("[TB] FAIL single_count1: got %0d want 1", count); end
        tick();
        #1;
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("[TB] FAIL single_count0: got %0d want 0", count); end
        n_cmp++; if (wEn !== 1'b0) begin n_bad++; $display("[TB] FAIL single_wen_off: got %b want 0", wEn); end
    endtask

    task automatic test_fill();
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_addr = 5'(i); in_data = 32'hA0 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("[TB] FAIL fill_count: got %0d want 4", count); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL fill_ready: got %b want 0", in_ready); end
        in_valid = 1'b1; in_addr = 5'd9; in_data = 32'h99;
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd4) begin n_bad++; $display("[TB] FAIL fill_refuse: got %0d want 4", count); end
        wb_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            n_cmp++; if (wEn !== 1'b1 || addrW !== 5'(i) || BusW !== 32'hA0 + 32'(i))
                begin n_bad++; $display("[TB] FAIL drain_%0d: got wEn=%b addr=%0d data=%h want 1 %0d %h", i, wEn, addrW, BusW, i, 32'hA0 + 32'(i)); end
            tick();
        end
        #1;
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("[TB] FAIL drain_empty: got %0d want 0", count); end
    endtask

    task automatic test_forward();
        wb_hold = 1'b1;
        in_valid = 1'b1; in_addr = 5'd7; in_data = 32'h1; tick();
        in_data = 32'h2; tick();
        in_valid = 1'b0; addrA = 5'd7;
        #1;
`ifdef WBQ_FWD_EN
        n_cmp++; if (fwdA_hit !== 1'b1 || fwdA_data !== 32'h2) begin n_bad++; $display("[TB] FAIL fwd_hit: got %b %h want 1 2", fwdA_hit, fwdA_data); end
        n_cmp++; if (raw_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL fwd_stall: got %b want 0", raw_stall); end
`else
        n_cmp++; if (raw_stall !== 1'b1) begin n_bad++; $display("[TB] FAIL stall_set: got %b want 1", raw_stall); end
        n_cmp++; if (fwdA_hit !== 1'b0 || fwdA_data !== 32'h0) begin n_bad++; $display("[TB] FAIL stall_nofwd: got %b %h want 0 0", fwdA_hit, fwdA_data); end
`endif
        addrA = 5'd0;
        #1;
        n_cmp++; if (fwdA_hit !== 1'b0 || raw_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL fwd_zero_addr: got hit=%b stall=%b want 0 0", fwdA_hit, raw_stall); end
        wb_hold = 1'b0;
        tick(); tick();
        #1;
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("[TB] FAIL fwd_drained: got %0d want 0", count); end
    endtask

    task automatic test_zero_addr();
        in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hDEAD;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL zero_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0 || wEn !== 1'b0) begin n_bad++; $display("[TB] FAIL zero_dropped: got count=%0d wEn=%b want 0 0", count, wEn); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] order [4];
        order = '{5'd12, 5'd13, 5'd20, 5'd0};
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_addr = 5'(10 + i); in_data = 32'h100 + 32'(i);
            tick();
        end
        wb_hold = 1'b0; in_addr = 5'd20; in_data = 32'h20;
        #1;
        n_cmp++; if (in_ready !== 1'b0 || wEn !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_full: got ready=%b wEn=%b want 0 1", in_ready, wEn); end
        tick();
        #1;
        n_cmp++; if (count !== 3'd3 || in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL b2b_3: got count=%0d ready=%b want 3 1", count, in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd3) begin n_bad++; $display("[TB] FAIL b2b_stay3: got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (wEn !== 1'b1 || addrW !== order[i]) begin n_bad++; $display("[TB] FAIL b2b_order_%0d: got wEn=%b addr=%0d want 1 %0d", i, wEn, addrW, order[i]); end
            tick();
            #1;
        end
        n_cmp++; if (count !== 3'd0) begin n_bad++; $display("[TB] FAIL b2b_empty: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = 5'(21 + i); in_data = 32'h200 + 32'(i);
            tick();
        end
        in_valid = 1'b0; rst_n = 1'b0; wb_hold = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (count !== 3'd0 || wEn !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_mid: got count=%0d wEn=%b ready=%b want 0 0 1", count, wEn, in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_cmp++; if (wEn !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_mid_nowrite_%0d: got %b want 0", i, wEn); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            in_valid = $urandom_range(0, 2) != 0;
            in_addr  = 5'($urandom_range(0, 7));
            in_data  = $urandom;
            wb_hold  = ($urandom_range(0, 3) == 0);
            addrA    = 5'($urandom_range(0, 7));
            addrB    = 5'($urandom_range(0, 7));
            #1;
            model_eval();
            n_cmp++; if (in_ready !== exp_ready || wEn !== exp_wen || count !== exp_count)
                begin n_bad++; $display("[TB] FAIL rand_ctrl c=%0d: got ready=%b wEn=%b count=%0d want %b %b %0d", c, in_ready, wEn, count, exp_ready, exp_wen, exp_count); end
            if (exp_wen) begin
                n_cmp++; if (addrW !== mq[0].a || BusW !== mq[0].d)
                    begin n_bad++; $display("[TB] FAIL rand_write c=%0d: got %0d %h want %0d %h", c, addrW, BusW, mq[0].a, mq[0].d); end
            end
            n_cmp++; if (fwdA_hit !== exp_hit_a || fwdA_data !== exp_data_a || fwdB_hit !== exp_hit_b || fwdB_data !== exp_data_b || raw_stall !== exp_stall)
                begin n_bad++; $display("[TB] FAIL rand_hazard c=%0d: got %b %h %b %h %b want %b %h %b %h %b", c, fwdA_hit, fwdA_data, fwdB_hit, fwdB_data, raw_stall, exp_hit_a, exp_data_a, exp_hit_b, exp_data_b, exp_stall); end
            tick();
        end
        rst_n = 1'b1; in_valid = 1'b0; wb_hold = 1'b0; addrA = '0; addrB = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_zero_addr();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
